// File: rtl/fp_conv_pkg.sv
// rtl/fp_conv_pkg.sv - shared constants and FSM encoding for the float/two's-complement convertors
//
// Purpose: default field widths, decoder FSM state encoding, and the bit
// positions of the packed 8-bit float {S, E[2:0], F[3:0]}.
// Ports: none (package).

package fp_conv_pkg;

    localparam int DEF_EXP_W  = 3;
    localparam int DEF_MANT_W = 4;
    localparam int DEF_OUT_W  = 12;

    // Packed float layout: [7] sign, [6:4] exponent, [3:0] significand.
    localparam int FLT_W        = 1 + DEF_EXP_W + DEF_MANT_W;
    localparam int FLT_SIGN_BIT = FLT_W - 1;
    localparam int FLT_EXP_MSB  = FLT_W - 2;
    localparam int FLT_EXP_LSB  = DEF_MANT_W;
    localparam int FLT_MANT_MSB = DEF_MANT_W - 1;
    localparam int FLT_MANT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SIGN  = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/sign_mag_to_twos.sv
// rtl/sign_mag_to_twos.sv - combinational sign/magnitude to two's-complement convertor
//
// Purpose: D = sign ? -mag : mag, W bits, carry-out of the negation dropped,
// so a negative zero magnitude yields 0.
// Ports:
//   sign  in   1  sign of the value
//   mag   in   W  unsigned magnitude
//   twos  out  W  two's-complement result

module sign_mag_to_twos #(
    parameter int W = 12
) (
    input  logic         sign,
    input  logic [W-1:0] mag,
    output logic [W-1:0] twos
);

    always_comb begin
        twos = mag;
        if (sign) begin
            twos = ~mag + W'(1);
        end
    end

endmodule

// File: rtl/fp_to_twos_decoder.sv
// rtl/fp_to_twos_decoder.sv - iterative 8-bit float to 12-bit two's-complement decoder
//
// Purpose: converts V = (-1)^S * F * 2^E into an OUT_W-bit two's-complement
// word using one left shift per cycle, then a sign step.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       float input valid
//   in_ready   out  1       decoder idle, can accept a float
//   in_sign    in   1       S
//   in_exp     in   EXP_W   E
//   in_mant    in   MANT_W  F
//   out_valid  out  1       out_data holds a result
//   out_ready  in   1       consumer accepts out_data
//   out_data   out  OUT_W   result, two's complement (0 when not valid)

module fp_to_twos_decoder
    import fp_conv_pkg::*;
#(
    parameter int EXP_W  = fp_conv_pkg::DEF_EXP_W,
    parameter int MANT_W = fp_conv_pkg::DEF_MANT_W,
    parameter int OUT_W  = fp_conv_pkg::DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data
);

    // Largest shifted magnitude must leave the MSB free for the sign.
    generate
        if (MANT_W + (2 ** EXP_W) - 1 > OUT_W - 1) begin : g_illegal_widths
            $error("fp_to_twos_decoder: MANT_W + 2^EXP_W - 1 exceeds OUT_W - 1");
        end
    endgenerate

    dec_state_t        state, state_n;
    logic [OUT_W-1:0]  acc, acc_n;
    logic [EXP_W-1:0]  cnt, cnt_n;
    logic              sign, sign_n;
    logic [OUT_W-1:0]  acc_signed;

    sign_mag_to_twos #(
        .W (OUT_W)
    ) u_sign_mag_to_twos (
        .sign (sign),
        .mag  (acc),
        .twos (acc_signed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            sign  <= sign_n;
        end
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        sign_n    = sign;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_n  = in_sign;
                    cnt_n   = in_exp;
                    acc_n   = {{(OUT_W - MANT_W){1'b0}}, in_mant};
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt != '0) begin
                    acc_n = acc << 1;
                    cnt_n = cnt - EXP_W'(1);
                end else begin
                    state_n = ST_SIGN;
                end
            end
            ST_SIGN: begin
                acc_n   = acc_signed;
                state_n = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_to_twos_decoder.sv
// tb/tb_fp_to_twos_decoder.sv - directed self-checking bench for fp_to_twos_decoder

module tb_fp_to_twos_decoder;
    import fp_conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [2:0]  in_exp = 3'd0;
    logic [3:0]  in_mant = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;

    int checks = 0;
    int failures = 0;

    fp_to_twos_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one float for exactly one edge.
    task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            in_valid = 1'b1;
            in_sign  = s;
            in_exp   = e;
            in_mant  = f;
            tick();
            in_valid = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20 && !ok; n++) begin
            tick();
            if (out_valid) begin
                ok  = 1'b1;
                lat = n;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h000) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h, required 1 0 000",
                     in_ready, out_valid, out_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_min_latency();
        bit ok; int lat;
        out_ready = 1'b1;
        send(1'b0, 3'd0, 4'd5, ok);
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != 2) begin
            failures++;
            $display("FAIL e0_latency: got %0d (ok=%b), required 2", lat, ok);
        end
        checks++;
        if (out_data !== 12'h005) begin
            failures++;
            $display("FAIL e0_data: got %h, required 005", out_data);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL e0_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_max_negative();
        bit ok; int lat;
        send(1'b1, 3'd7, 4'd15, ok);
        // Scramble inputs mid-operation; they must not be re-sampled.
        in_sign = 1'b0; in_exp = 3'd1; in_mant = 4'd2;
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != 9) begin
            failures++;
            $display("FAIL e7_latency: got %0d (ok=%b), required 9", lat, ok);
        end
        checks++;
        if (out_data !== 12'h880) begin
            failures++;
            $display("FAIL e7_data: got %h, required 880", out_data);
        end
        consume();
    endtask

    task automatic test_negative_zero();
        bit ok; int lat;
        send(1'b1, 3'd3, 4'd0, ok);
        wait_done(lat, ok);
        checks++;
        if (!ok || out_data !== 12'h000) begin
            failures++;
            $display("FAIL neg_zero: got %h (ok=%b), required 000", out_data, ok);
        end
        consume();
    endtask

    task automatic test_stall();
        bit ok; int lat;
        send(1'b0, 3'd2, 4'd9, ok);
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != 4) begin
            failures++;
            $display("FAIL stall_latency: got %0d (ok=%b), required 4", lat, ok);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sign = 1'b1; in_exp = 3'd7; in_mant = 4'd15;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'h024 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: out_valid=%b out_data=%h in_ready=%b, required 1 024 0",
                         c, out_valid, out_data, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        consume();
        // Dropped pulses must not have queued a second result.
        for (int c = 0; c < 12; c++) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_no_queue: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat;
        send(1'b1, 3'd6, 4'd3, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h000) begin
            failures++;
            $display("FAIL reset_abort: in_ready=%b out_valid=%b out_data=%h, required 1 0 000",
                     in_ready, out_valid, out_data);
        end
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: out_valid=%b, required 0", out_valid);
        end
        send(1'b0, 3'd1, 4'd1, ok);
        wait_done(lat, ok);
        checks++;
        if (!ok || out_data !== 12'h002 || lat != 3) begin
            failures++;
            $display("FAIL after_reset_decode: got %h lat=%0d (ok=%b), required 002 lat=3", out_data, lat, ok);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok; int lat;
        send(1'b0, 3'd4, 4'd3, ok);
        wait_done(lat, ok);
        checks++;
        if (!ok || out_data !== 12'h030) begin
            failures++;
            $display("FAIL b2b_first: got %h (ok=%b), required 030", out_data, ok);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
        end
        send(1'b1, 3'd1, 4'd7, ok);
        wait_done(lat, ok);
        checks++;
        if (!ok || out_data !== 12'hFF2 || lat != 3) begin
            failures++;
            $display("FAIL b2b_second: got %h lat=%0d (ok=%b), required ff2 lat=3", out_data, lat, ok);
        end
        consume();
    endtask

    task automatic test_sweep();
        bit ok; int lat; int mag;
        logic [7:0]  v;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic [11:0] expv;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            s = v[FLT_SIGN_BIT];
            e = v[FLT_EXP_MSB:FLT_EXP_LSB];
            f = v[FLT_MANT_MSB:FLT_MANT_LSB];
            mag  = int'(f) * (1 << e);
            expv = s ? 12'(-mag) : 12'(mag);
            send(s, e, f, ok);
            wait_done(lat, ok);
            checks++;
            if (!ok || $isunknown(out_data) || out_data !== expv) begin
                failures++;
                $display("FAIL sweep_data v=%h: got %h (ok=%b), required %h", v, out_data, ok, expv);
            end
            checks++;
            if (lat != int'(e) + 2) begin
                failures++;
                $display("FAIL sweep_latency v=%h: got %0d, required %0d", v, lat, int'(e) + 2);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_max_negative();
        test_negative_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
